hazard_scoreboard: RTL and testbench

Issue-side hazard controller for the 5-stage MIPS pipeline. It is the producer-tracking counterpart of the EX-stage forwarding logic: it records every register-writing instruction leaving ID and the number of cycles until its result can be forwarded. It holds PC and IF/ID and injects an ID/EX bubble while a decoded instruction depends on a result that no forwarding path can supply yet (load-use, multi-cycle multiply). It sits beside the decoder in ID.

---
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_hazard_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard controller: tracks producer latency per register and stalls dependent issue.
// Define HAZARD_MULDIV_EN to compile in multiply latency tracking and the mul_busy stall.
module hazard_scoreboard #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ID_valid_i,
    input  logic [4:0]       RSaddr_i,
    input  logic [4:0]       RTaddr_i,
    input  logic             RSuse_i,
    input  logic             RTuse_i,
    input  logic [4:0]       Regdst_i,
    input  logic             RegWrite_i,
    input  logic             MemRead_i,
    input  logic             MulDiv_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [2:0] MulLat = 3'(MUL_LAT);

    // Entry 0 exists only so the array can be indexed directly; it is never loaded.
    logic [31:0][2:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rs_haz, rt_haz, raw_haz, struct_haz, stall, issue;
    logic [2:0] load_val;

`ifdef HAZARD_MULDIV_EN
    logic [2:0] mul_busy_q, mul_busy_d;

    always_comb begin
        struct_haz = ID_valid_i & MulDiv_i & (mul_busy_q != 3'd0);
        mul_busy_d = (mul_busy_q != 3'd0) ? mul_busy_q - 3'd1 : 3'd0;
        if (issue && MulDiv_i) begin
            mul_busy_d = MulLat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mul_busy_q <= 3'd0;
        end else begin
            mul_busy_q <= mul_busy_d;
        end
    end

    always_comb begin
        if (MulDiv_i) begin
            load_val = MulLat;
        end else if (MemRead_i) begin
            load_val = 3'd1;
        end else begin
            load_val = 3'd0;
        end
    end
`else
    logic unused_muldiv;
    assign unused_muldiv = MulDiv_i;
    assign struct_haz    = 1'b0;
    assign load_val      = MemRead_i ? 3'd1 : 3'd0;
`endif

    always_comb begin
        rs_haz  = RSuse_i && (RSaddr_i != 5'd0) && (pend_q[RSaddr_i] != 3'd0);
        rt_haz  = RTuse_i && (RTaddr_i != 5'd0) && (pend_q[RTaddr_i] != 3'd0);
        raw_haz = ID_valid_i & (rs_haz | rt_haz);
        stall   = raw_haz | struct_haz;
        issue   = ID_valid_i & ~stall;
    end

    assign stall_o     = stall;
    assign bubble_o    = stall;
    assign stall_cnt_o = cnt_q;

    // Every entry counts down; the register being written this edge takes the new latency.
    always_comb begin
        pend_d = '0;
        for (int i = 1; i < 32; i++) begin
            pend_d[i] = (pend_q[i] != 3'd0) ? pend_q[i] - 3'd1 : 3'd0;
            if (issue && RegWrite_i && (Regdst_i == 5'(i))) begin
                pend_d[i] = load_val;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus queues per-cycle expectations, monitor checks.
module tb_hazard_scoreboard;

    localparam int CW = 4;
`ifdef HAZARD_MULDIV_EN
    localparam int ML = 4;
`else
    localparam int ML = 0;
`endif
    localparam int MD = (ML > 2) ? ML - 2 : 0;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          ID_valid_i = 1'b0;
    logic [4:0]    RSaddr_i = '0, RTaddr_i = '0, Regdst_i = '0;
    logic          RSuse_i = 1'b0, RTuse_i = 1'b0, RegWrite_i = 1'b0;
    logic          MemRead_i = 1'b0, MulDiv_i = 1'b0;
    logic          stall_o, bubble_o;
    logic [CW-1:0] stall_cnt_o;

    typedef struct {
        int stall;
        int cnt;
        int tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    hazard_scoreboard #(.MUL_LAT(4), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ID_valid_i  (ID_valid_i),
        .RSaddr_i    (RSaddr_i),
        .RTaddr_i    (RTaddr_i),
        .RSuse_i     (RSuse_i),
        .RTuse_i     (RTuse_i),
        .Regdst_i    (Regdst_i),
        .RegWrite_i  (RegWrite_i),
        .MemRead_i   (MemRead_i),
        .MulDiv_i    (MulDiv_i),
        .stall_o     (stall_o),
        .bubble_o    (bubble_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input int tag, input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s tag=%0d actual=%0d required=%0d", nm, tag, act, req);
        end
    endtask

    // One ID-stage cycle: inputs held from just after the edge, expectation queued for the monitor.
    task automatic drive(input int v, input int rs, input int rt, input int rsu, input int rtu,
                         input int rd, input int rw, input int mr, input int md,
                         input int es, input int ec, input int tag);
        @(posedge clk);
        #1;
        ID_valid_i = v[0];
        RSaddr_i   = 5'(rs);
        RTaddr_i   = 5'(rt);
        RSuse_i    = rsu[0];
        RTuse_i    = rtu[0];
        Regdst_i   = 5'(rd);
        RegWrite_i = rw[0];
        MemRead_i  = mr[0];
        MulDiv_i   = md[0];
        exp_q.push_back('{es, ec, tag});
    endtask

    task automatic idle(input int ec, input int tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ec, tag);
    endtask

    task automatic do_reset(input int tag);
        #6;
        rst_i      = 1'b0;
        ID_valid_i = 1'b0;
        RegWrite_i = 1'b0;
        #1;
        chk(tag, "reset_stall", int'(stall_o), 0);
        chk(tag, "reset_bubble", int'(bubble_o), 0);
        chk(tag, "reset_cnt", int'(stall_cnt_o), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, "stall", int'(stall_o), e.stall);
            chk(e.tag, "bubble", int'(bubble_o), e.stall);
            chk(e.tag, "cnt", int'(stall_cnt_o), e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(0);

        // Load-use: one stall, then the add issues.
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 10);
        drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 1, 0, 11);
        drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 1, 12);
        idle(1, 13);

        // ALU chain forwards without stalling.
        do_reset(20);
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 21);
        drive(1, 2, 2, 1, 1, 5, 1, 0, 0, 0, 0, 22);
        idle(0, 23);

        // Register zero, unused rs, and an rt-only dependency.
        do_reset(30);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 31);
        drive(1, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0, 32);
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 33);
        drive(1, 2, 4, 0, 1, 0, 0, 0, 0, 0, 0, 34);
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 35);
        drive(1, 1, 9, 0, 1, 10, 1, 0, 0, 1, 0, 36);
        drive(1, 1, 9, 0, 1, 10, 1, 0, 0, 0, 1, 37);
        idle(1, 38);

        // Multiply dependency.
        do_reset(40);
        drive(1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 41);
        for (int i = 0; i < ML; i++) drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 1, i, 42);
        drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 0, ML, 43);
        idle(ML, 44);

        // Back-to-back independent multiplies contend for the multiplier.
        do_reset(50);
        drive(1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 51);
        for (int i = 0; i < ML; i++) drive(1, 1, 2, 1, 1, 8, 1, 0, 1, 1, i, 52);
        drive(1, 1, 2, 1, 1, 8, 1, 0, 1, 0, ML, 53);
        idle(ML, 54);

        // Pending multiply keeps counting down through invalid cycles.
        do_reset(60);
        drive(1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 61);
        drive(0, 6, 6, 1, 1, 7, 1, 0, 0, 0, 0, 62);
        drive(0, 6, 6, 1, 1, 7, 1, 0, 0, 0, 0, 63);
        for (int i = 0; i < MD; i++) drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 1, i, 64);
        drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 0, MD, 65);

        // Later load to the same register overrides the multiply latency.
        do_reset(70);
        drive(1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 71);
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 72);
        drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 1, 0, 73);
        drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 0, 1, 74);

        // Reset asserted in the middle of a load-use stall.
        do_reset(80);
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 81);
        drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 1, 0, 82);
        drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 1, 83);
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 1, 84);
        drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 1, 1, 85);
        #6;
        rst_i = 1'b0;
        #1;
        chk(86, "midrst_stall", int'(stall_o), 0);
        chk(86, "midrst_bubble", int'(bubble_o), 0);
        chk(86, "midrst_cnt", int'(stall_cnt_o), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 87);
        idle(0, 88);

        // Saturation: self-dependent loads stall every other cycle, 20 stalls total.
        do_reset(90);
        for (int k = 0; k < 20; k++) begin
            drive(1, 2, 0, 1, 0, 2, 1, 1, 0, 0, (k < 15) ? k : 15, 91);
            drive(1, 2, 0, 1, 0, 2, 1, 1, 0, 1, (k < 15) ? k : 15, 92);
        end
        idle(15, 93);
        do_reset(94);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
